max7219_spi_driver: RTL

Transmit-side driver for the MAX7219 LED driver's 3-wire serial interface (DIN/CLK/LOAD). Accepts one register write at a time (4-bit address, 8-bit data) over a valid/ready handshake. Serialises it as a 16-bit frame, MSB first, then strobes LOAD. Sits between the clock display formatter and the chip pins, and drives the existing MAX7219 bus-functional model directly.

---
 rtl/max7219_spi_driver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/max7219_spi_driver.sv
// max7219_spi_driver
// Transmit-side driver for the MAX7219 3-wire serial interface (DIN/CLK/LOAD).
// Accepts one register write (4-bit address, 8-bit data) per valid/ready
// handshake, shifts it out as a 16-bit frame {4'h0, addr, data} MSB first,
// then raises LOAD to latch it into the chip.
//
// Optional feature: define MAX7219_INIT_EN to have the driver send a
// five-frame configuration sequence on its own after reset (display test
// off, scan limit 7, decode mode, intensity, normal operation) before it
// raises o_ready for the first time.

module max7219_spi_driver #(
  parameter int         CLK_DIV        = 2,      // half-period of o_serial_clk in i_clk cycles, >= 1
  parameter logic [7:0] INIT_DECODE    = 8'hFF,  // decode-mode value sent by the init sequence
  parameter logic [3:0] INIT_INTENSITY = 4'h8    // intensity value sent by the init sequence
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_frame_done,
  output logic       o_serial_din,
  output logic       o_serial_clk,
  output logic       o_serial_load
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_GAP   = 3'd3
`ifdef MAX7219_INIT_EN
    ,
    ST_INIT  = 3'd4
`endif
  } state_t;

`ifdef MAX7219_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;      // cycles spent in the current phase
  logic             clk_phase;    // 0: serial clock low half, 1: high half
  logic [15:0]      shreg;        // frame being shifted, MSB on the wire
  logic [3:0]       bit_cnt;      // index of the bit currently on DIN
  logic             div_last;     // last cycle of the current phase
  logic             load_frame;   // a new frame enters the shift register
  logic [15:0]      frame_in;

  assign div_last = (div_cnt == DIV_LAST);

`ifdef MAX7219_INIT_EN
  logic [2:0] init_idx;           // number of init frames already launched

  // Register/data pairs of the power-up configuration, in send order.
  function automatic logic [11:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = {4'hF, 8'h00};                   // display test off
      3'd1:    init_cmd = {4'hB, 8'h07};                   // scan limit 7
      3'd2:    init_cmd = {4'h9, INIT_DECODE};             // decode mode
      3'd3:    init_cmd = {4'hA, {4'h0, INIT_INTENSITY}};  // intensity
      default: init_cmd = {4'hC, 8'h01};                   // normal operation
    endcase
  endfunction

  assign load_frame = ((state == ST_IDLE) && i_valid) || (state == ST_INIT);
  assign frame_in   = (state == ST_INIT) ? {4'h0, init_cmd(init_idx)}
                                         : {4'h0, i_addr, i_data};

  // Count launched init frames so GAP knows whether to start another one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      init_idx <= 3'd0;
    else if (state == ST_INIT)
      init_idx <= init_idx + 3'd1;
  end
`else
  assign load_frame = (state == ST_IDLE) && i_valid;
  assign frame_in   = {4'h0, i_addr, i_data};
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, independent of statement order.
    if (i_reset)
      state <= RESET_STATE;
    else
      state <= state_next;
  end

  // Next-state logic: each timed state leaves on the last cycle of its phase.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      ST_IDLE:  if (i_valid) state_next = ST_SHIFT;
      ST_SHIFT: if (div_last && clk_phase && (bit_cnt == 4'd0)) state_next = ST_HOLD;
      ST_HOLD:  if (div_last) state_next = ST_GAP;
`ifdef MAX7219_INIT_EN
      ST_INIT:  state_next = ST_SHIFT;
      ST_GAP:   if (div_last) state_next = (init_idx == 3'd5) ? ST_IDLE : ST_INIT;
`else
      ST_GAP:   if (div_last) state_next = ST_IDLE;
`endif
      default:  state_next = RESET_STATE;
    endcase
  end

  // Phase divider: runs in the timed states and wraps at every phase boundary.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      div_cnt <= '0;
    else if ((state == ST_SHIFT) || (state == ST_HOLD) || (state == ST_GAP))
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
    else
      div_cnt <= '0;
  end

  // Serial clock phase: toggles at each phase boundary while shifting, and
  // is back at low when SHIFT exits after the last high half.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      clk_phase <= 1'b0;
    else if (state != ST_SHIFT)
      clk_phase <= 1'b0;
    else if (div_last)
      clk_phase <= ~clk_phase;
  end

  // Shift register and bit counter: load on launch, advance after each high
  // half so DIN is stable across the chip's sampling edge mid-bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load_frame) begin
      shreg   <= frame_in;
      bit_cnt <= 4'd15;
    end else if ((state == ST_SHIFT) && div_last && clk_phase) begin
      shreg   <= {shreg[14:0], 1'b0};
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

  // Outputs decoded from state; reset state gives LOAD high, CLK/DIN low.
  always_comb begin
    o_ready       = (state == ST_IDLE);
    o_serial_load = !((state == ST_SHIFT) || (state == ST_HOLD));
    o_serial_clk  = (state == ST_SHIFT) && clk_phase;
    o_serial_din  = (state == ST_SHIFT) && shreg[15];
    o_frame_done  = (state == ST_GAP) && (div_cnt == '0);
  end

endmodule
